slice_collector: RTL and testbench

//   Downstream stage of the permutation datapath. Captures the 64 consecutive
//   25-bit permuted slices (newLine) of one 1600-bit state into a 64-entry buffer.

---
 rtl/slice_collector.sv | 123 ++++++++++++
 tb/tb_slice_collector.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/slice_collector.sv
// slice_collector: captures one frame of DEPTH permuted slices into a buffer,
// then drains them in index order over a valid/ready interface.
module slice_collector #(
    parameter int WIDTH  = 25,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [WIDTH-1:0]  in_slice,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [WIDTH-1:0]  out_slice,
    output logic [ADDR_W-1:0] out_index,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic              protocol_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [ADDR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic              done_reg, done_next;
    logic              err_reg, err_next;
    logic              wr_en;
    logic [WIDTH-1:0]  mem [DEPTH];

    // Control registers: state, pointers, done pulse and sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            done_reg   <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            done_reg   <= done_next;
            err_reg    <= err_next;
        end
    end

    // Slice buffer write port; contents survive reset, but no write happens during it.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem[wr_ptr_reg] <= in_slice;
        end
    end

    // Next-state logic: capture sequencing, drain handshake and error detection.
    always_comb begin
        state_next  = state_reg;
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        done_next   = 1'b0;
        err_next    = err_reg;
        wr_en       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next  = CAPTURE;
                    wr_ptr_next = '0;
                    err_next    = 1'b0;
                end
                // A slice arriving in IDLE (even alongside start) is dropped and flagged.
                if (in_valid) begin
                    err_next = 1'b1;
                end
            end
            CAPTURE: begin
                if (in_valid) begin
                    wr_en       = 1'b1;
                    wr_ptr_next = wr_ptr_reg + 1'b1;
                    if (wr_ptr_reg == LAST_IDX) begin
                        state_next  = DRAIN;
                        rd_ptr_next = '0;
                    end
                end
                if (start) begin
                    err_next = 1'b1;
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    rd_ptr_next = rd_ptr_reg + 1'b1;
                    if (rd_ptr_reg == LAST_IDX) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end
                end
                if (in_valid || start) begin
                    err_next = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Drain-side outputs read straight from the buffer; forced to zero outside DRAIN.
    assign out_valid    = (state_reg == DRAIN);
    assign out_slice    = out_valid ? mem[rd_ptr_reg] : '0;
    assign out_index    = out_valid ? rd_ptr_reg : '0;
    assign out_last     = out_valid && (rd_ptr_reg == LAST_IDX);
    assign busy         = (state_reg != IDLE);
    assign done         = done_reg;
    assign protocol_err = err_reg;

endmodule

// File: tb/tb_slice_collector.sv
// tb_slice_collector: randomized frame capture/drain against a queue-style model.
module tb_slice_collector;

    localparam int WIDTH  = 25;
    localparam int DEPTH  = 64;
    localparam int ADDR_W = 6;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              in_valid = 1'b0;
    logic [WIDTH-1:0]  in_slice = '0;
    logic              out_ready = 1'b0;
    logic              out_valid;
    logic [WIDTH-1:0]  out_slice;
    logic [ADDR_W-1:0] out_index;
    logic              out_last;
    logic              busy;
    logic              done;
    logic              protocol_err;

    int pass_cnt  = 0;
    int total_cnt = 0;
    bit exp_err   = 1'b0;
    logic [WIDTH-1:0] frame_data [DEPTH];

    slice_collector #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_slice(in_slice),
        .out_ready(out_ready), .out_valid(out_valid), .out_slice(out_slice),
        .out_index(out_index), .out_last(out_last), .busy(busy), .done(done),
        .protocol_err(protocol_err)
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        start = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        step();
        rst = 1'b0;
        exp_err = 1'b0;
    endtask

    task automatic start_frame(input bit with_valid);
        start = 1'b1;
        in_valid = with_valid;
        in_slice = ~frame_data[0];
        step();
        start = 1'b0;
        in_valid = 1'b0;
        exp_err = with_valid;
        total_cnt++; if (busy !== 1'b1) $display("FAIL start_busy got=%0b exp=1", busy); else pass_cnt++;
        total_cnt++; if (done !== 1'b0) $display("FAIL start_done got=%0b exp=0", done); else pass_cnt++;
        total_cnt++; if (protocol_err !== exp_err) $display("FAIL start_err got=%0b exp=%0b", protocol_err, exp_err); else pass_cnt++;
    endtask

    // Write n slices from frame_data; optionally pulse start in the gap after slice err_at.
    task automatic capture(input int n, input int err_at, input bit rand_gaps);
        int gaps;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_slice = frame_data[i];
            total_cnt++; if (busy !== 1'b1 || out_valid !== 1'b0) $display("FAIL cap_state i=%0d got busy=%0b valid=%0b exp busy=1 valid=0", i, busy, out_valid); else pass_cnt++;
            total_cnt++; if (protocol_err !== exp_err) $display("FAIL cap_err i=%0d got=%0b exp=%0b", i, protocol_err, exp_err); else pass_cnt++;
            step();
            in_valid = 1'b0;
            if (i == DEPTH - 1) begin
                total_cnt++; if (out_valid !== 1'b1) $display("FAIL drain_latency got=%0b exp=1", out_valid); else pass_cnt++;
            end else begin
                gaps = rand_gaps ? int'($urandom_range(1, 3)) : 1;
                for (int g = 0; g < gaps; g++) begin
                    start = (i == err_at) && (g == 0);
                    step();
                    if (start) exp_err = 1'b1;
                    start = 1'b0;
                end
            end
        end
    endtask

    // Drain up to stop_at slices; mode 0 ready high, 1 toggling, 2 random.
    task automatic drain(input int mode, input int stop_at, input bit inject);
        int cnt = 0;
        int cyc = 0;
        bit ready;
        bit prev_stall = 1'b0;
        logic [WIDTH-1:0]  held_slice = '0;
        logic [ADDR_W-1:0] held_idx = '0;
        while (cnt < stop_at && cyc < 1000) begin
            case (mode)
                0: ready = 1'b1;
                1: ready = (cyc % 2 == 0);
                default: ready = 1'($urandom_range(0, 1));
            endcase
            out_ready = ready;
            in_valid = inject && (cyc == 1);
            in_slice = WIDTH'($urandom);
            total_cnt++; if (out_valid !== 1'b1 || busy !== 1'b1) $display("FAIL drain_valid n=%0d got valid=%0b busy=%0b exp 1", cnt, out_valid, busy); else pass_cnt++;
            total_cnt++; if (out_index !== ADDR_W'(cnt)) $display("FAIL drain_index got=%0d exp=%0d", out_index, cnt); else pass_cnt++;
            total_cnt++; if (out_slice !== frame_data[cnt]) $display("FAIL drain_slice idx=%0d got=%h exp=%h", cnt, out_slice, frame_data[cnt]); else pass_cnt++;
            total_cnt++; if (out_last !== (cnt == DEPTH - 1)) $display("FAIL drain_last idx=%0d got=%0b exp=%0b", cnt, out_last, cnt == DEPTH - 1); else pass_cnt++;
            total_cnt++; if (protocol_err !== exp_err) $display("FAIL drain_err got=%0b exp=%0b", protocol_err, exp_err); else pass_cnt++;
            if (prev_stall) begin
                total_cnt++; if (out_slice !== held_slice || out_index !== held_idx) $display("FAIL stall_hold got=%0d/%h exp=%0d/%h", out_index, out_slice, held_idx, held_slice); else pass_cnt++;
            end
            held_slice = out_slice;
            held_idx = out_index;
            prev_stall = !ready;
            step();
            if (in_valid) exp_err = 1'b1;
            in_valid = 1'b0;
            if (ready) cnt++;
            cyc++;
        end
        out_ready = 1'b0;
        total_cnt++; if (cnt != stop_at) $display("FAIL drain_timeout got=%0d exp=%0d", cnt, stop_at); else pass_cnt++;
        if (stop_at == DEPTH) begin
            total_cnt++; if (out_valid !== 1'b0 || busy !== 1'b0) $display("FAIL drain_end got valid=%0b busy=%0b exp 0", out_valid, busy); else pass_cnt++;
            total_cnt++; if (done !== 1'b1) $display("FAIL done_pulse got=%0b exp=1", done); else pass_cnt++;
            total_cnt++; if (protocol_err !== exp_err) $display("FAIL end_err got=%0b exp=%0b", protocol_err, exp_err); else pass_cnt++;
        end
        $display("drain: mode=%0d transfers=%0d cycles=%0d", mode, cnt, cyc);
    endtask

    task automatic check_done_low(input string tag);
        step();
        total_cnt++; if (done !== 1'b0) $display("FAIL %s_done_once got=%0b exp=0", tag, done); else pass_cnt++;
    endtask

    task automatic check_abandoned(input string tag);
        total_cnt++; if (busy !== 1'b0 || out_valid !== 1'b0) $display("FAIL %s_idle got busy=%0b valid=%0b exp 0", tag, busy, out_valid); else pass_cnt++;
        total_cnt++; if (done !== 1'b0 || protocol_err !== 1'b0) $display("FAIL %s_flags got done=%0b err=%0b exp 0", tag, done, protocol_err); else pass_cnt++;
        step();
        total_cnt++; if (done !== 1'b0 || busy !== 1'b0) $display("FAIL %s_nodone got done=%0b busy=%0b exp 0", tag, done, busy); else pass_cnt++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b1;
        step();
        step();
        total_cnt++; if (out_valid !== 1'b0 || out_last !== 1'b0) $display("FAIL reset_out got valid=%0b last=%0b exp 0", out_valid, out_last); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0 || done !== 1'b0 || protocol_err !== 1'b0) $display("FAIL reset_flags got %0b%0b%0b exp 000", busy, done, protocol_err); else pass_cnt++;
        total_cnt++; if (out_index !== '0 || out_slice !== '0) $display("FAIL reset_data got=%0d/%h exp=0/0", out_index, out_slice); else pass_cnt++;
        rst = 1'b0;
        start = 1'b0;
        step();
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_start_ignored got=%0b exp=0", busy); else pass_cnt++;
        $display("test_reset done");
    endtask

    task automatic test_basic();
        do_reset();
        for (int i = 0; i < DEPTH; i++) frame_data[i] = WIDTH'(i);
        start_frame(1'b0);
        capture(DEPTH, -1, 1'b0);
        drain(0, DEPTH, 1'b0);
        check_done_low("basic");
    endtask

    task automatic test_stall();
        do_reset();
        for (int i = 0; i < DEPTH; i++) frame_data[i] = WIDTH'(i);
        start_frame(1'b0);
        capture(DEPTH, -1, 1'b0);
        drain(1, DEPTH, 1'b1);
        check_done_low("stall");
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < DEPTH; i++) frame_data[i] = WIDTH'($urandom);
        start_frame(1'b0);
        capture(DEPTH, -1, 1'b1);
        drain(2, DEPTH, 1'b0);
        check_done_low("random");
    endtask

    task automatic test_errors();
        do_reset();
        for (int i = 0; i < DEPTH; i++) frame_data[i] = WIDTH'($urandom);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        exp_err = 1'b1;
        total_cnt++; if (protocol_err !== 1'b1 || busy !== 1'b0) $display("FAIL idle_valid got err=%0b busy=%0b exp 1/0", protocol_err, busy); else pass_cnt++;
        start_frame(1'b0);
        capture(DEPTH, 10, 1'b0);
        drain(0, DEPTH, 1'b0);
        check_done_low("errors");
        total_cnt++; if (protocol_err !== 1'b1) $display("FAIL err_sticky got=%0b exp=1", protocol_err); else pass_cnt++;
        start_frame(1'b0);
        do_reset();
    endtask

    task automatic test_start_with_valid();
        do_reset();
        for (int i = 0; i < DEPTH; i++) frame_data[i] = WIDTH'($urandom);
        start_frame(1'b1);
        capture(DEPTH, -1, 1'b1);
        drain(0, DEPTH, 1'b0);
        check_done_low("startvalid");
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < DEPTH; i++) frame_data[i] = WIDTH'($urandom);
        start_frame(1'b0);
        capture(40, 10, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_err = 1'b0;
        check_abandoned("rst_capture");
        start_frame(1'b0);
        capture(DEPTH, -1, 1'b1);
        drain(0, 20, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_abandoned("rst_drain");
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < DEPTH; i++) frame_data[i] = WIDTH'(25'h1FFFFFF ^ i);
        start_frame(1'b0);
        capture(DEPTH, -1, 1'b0);
        drain(0, DEPTH, 1'b0);
        start_frame(1'b0);
        capture(DEPTH, -1, 1'b0);
        drain(2, DEPTH, 1'b0);
        check_done_low("b2b");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_random();
        test_errors();
        test_start_with_valid();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
